// File: rtl/aclk_controller.sv
// rtl/aclk_controller.sv - alarm clock keypad entry sequencer
// Moore FSM with registered selects, one-cycle load strobes and idle timeout.
module aclk_controller #(
  parameter int TIMEOUT = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        one_second,
  input  logic [3:0]  key,
  output logic [15:0] key_buffer,
  output logic        show_new_time,
  output logic        show_alarm,
  output logic        load_new_alarm,
  output logic        load_new_time
);

  typedef enum logic [2:0] {
    S_SHOW_TIME  = 3'd0,
    S_KEY_STORED = 3'd1,
    S_KEY_WAITED = 3'd2,
    S_KEY_ENTRY  = 3'd3,
    S_SHOW_ALARM = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ALARM = 4'd10;
  localparam logic [3:0] KEY_TIME  = 4'd11;
  localparam logic [3:0] CNT_LAST  = 4'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        show_new_time_q, show_new_time_d;
  logic        show_alarm_q, show_alarm_d;
  logic        ld_alarm_q, ld_alarm_d;
  logic        ld_time_q, ld_time_d;

  logic is_digit, is_none, timeout_hit;

  assign is_digit    = (key <= 4'd9);
  assign is_none     = (key >= 4'd12);
  assign timeout_hit = one_second && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = 4'd0;
    ld_alarm_d = 1'b0;
    ld_time_d  = 1'b0;
    case (state_q)
      S_SHOW_TIME: begin
        if (is_digit) begin
          state_d = S_KEY_STORED;
          buf_d   = {12'h000, key};
        end else if (key == KEY_ALARM) begin
          state_d = S_SHOW_ALARM;
        end
      end
      S_KEY_STORED: state_d = S_KEY_WAITED;
      // Release beats a coincident timeout; a held key can only time out.
      S_KEY_WAITED: begin
        if (is_none) begin
          state_d = S_KEY_ENTRY;
        end else if (timeout_hit) begin
          state_d = S_SHOW_TIME;
          buf_d   = 16'h0000;
        end else begin
          cnt_d = cnt_q + {3'b000, one_second};
        end
      end
      S_KEY_ENTRY: begin
        if (is_digit) begin
          state_d = S_KEY_STORED;
          buf_d   = {buf_q[11:0], key};
        end else if (key == KEY_ALARM) begin
          state_d    = S_SHOW_TIME;
          ld_alarm_d = 1'b1;
        end else if (key == KEY_TIME) begin
          state_d   = S_SHOW_TIME;
          ld_time_d = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_SHOW_TIME;
          buf_d   = 16'h0000;
        end else begin
          cnt_d = cnt_q + {3'b000, one_second};
        end
      end
      S_SHOW_ALARM: begin
        if (key != KEY_ALARM) state_d = S_SHOW_TIME;
      end
      default: state_d = S_SHOW_TIME;
    endcase
    show_new_time_d = (state_d == S_KEY_STORED) || (state_d == S_KEY_WAITED) ||
                      (state_d == S_KEY_ENTRY);
    show_alarm_d    = (state_d == S_SHOW_ALARM);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_SHOW_TIME;
      buf_q           <= 16'h0000;
      cnt_q           <= 4'd0;
      show_new_time_q <= 1'b0;
      show_alarm_q    <= 1'b0;
      ld_alarm_q      <= 1'b0;
      ld_time_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      buf_q           <= buf_d;
      cnt_q           <= cnt_d;
      show_new_time_q <= show_new_time_d;
      show_alarm_q    <= show_alarm_d;
      ld_alarm_q      <= ld_alarm_d;
      ld_time_q       <= ld_time_d;
    end
  end

  assign key_buffer     = buf_q;
  assign show_new_time  = show_new_time_q;
  assign show_alarm     = show_alarm_q;
  assign load_new_alarm = ld_alarm_q;
  assign load_new_time  = ld_time_q;

endmodule

// File: tb/tb_aclk_controller.sv
// tb/tb_aclk_controller.sv - directed self-checking bench for aclk_controller
module tb_aclk_controller;

  logic        clock;
  logic        reset_n;
  logic        one_second;
  logic [3:0]  key;
  logic [15:0] key_buffer;
  logic        show_new_time;
  logic        show_alarm;
  logic        load_new_alarm;
  logic        load_new_time;

  int n_tests = 0;
  int n_fail  = 0;

  aclk_controller #(.TIMEOUT(3)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .one_second     (one_second),
    .key            (key),
    .key_buffer     (key_buffer),
    .show_new_time  (show_new_time),
    .show_alarm     (show_alarm),
    .load_new_alarm (load_new_alarm),
    .load_new_time  (load_new_time)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Packed view of every output except the buffer: {snt, sa, lna, lnt}.
  function automatic logic [3:0] flags();
    return {show_new_time, show_alarm, load_new_alarm, load_new_time};
  endfunction

  task automatic press(input logic [3:0] d, input int hold);
    key = d;
    repeat (hold) tick();
    key = 4'd15;
    tick();
  endtask

  task automatic pulse();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    key        = 4'd15;
    one_second = 1'b0;
    tick();
    tick();
    check("reset_buf", 32'(key_buffer), 32'h0);
    check("reset_flags", 32'(flags()), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", {12'h0, flags(), key_buffer}, 32'h0);
    end

    // Time entry 1,2,3,4 then TIME
    press(4'd1, 2);
    check("te_buf1", 32'(key_buffer), 32'h0001);
    press(4'd2, 2);
    check("te_buf2", 32'(key_buffer), 32'h0012);
    press(4'd3, 2);
    check("te_snt3", 32'(show_new_time), 32'h1);
    press(4'd4, 2);
    check("te_buf4", 32'(key_buffer), 32'h1234);
    check("te_flags4", 32'(flags()), 32'b1000);
    key = 4'd11;
    tick();
    check("te_strobe", 32'(flags()), 32'b0001);
    check("te_strobe_buf", 32'(key_buffer), 32'h1234);
    key = 4'd15;
    tick();
    check("te_after", 32'(flags()), 32'b0000);

    // Wrap: 1..6 then ALARM
    for (int d = 1; d <= 6; d++) press(4'(d), 2);
    check("wrap_buf", 32'(key_buffer), 32'h3456);
    key = 4'd10;
    tick();
    check("wrap_strobe", 32'(flags()), 32'b0010);
    check("wrap_strobe_buf", 32'(key_buffer), 32'h3456);
    key = 4'd15;
    tick();
    check("wrap_after", 32'(flags()), 32'b0000);

    // Held digit shifts once
    key = 4'd7;
    repeat (10) tick();
    check("hold7_buf", 32'(key_buffer), 32'h0007);
    key = 4'd15;
    tick();
    press(4'd8, 10);
    check("hold8_buf", 32'(key_buffer), 32'h0078);
    key = 4'd11;
    tick();
    key = 4'd15;
    tick();

    // Timeout after 3 pulses
    press(4'd5, 2);
    pulse();
    pulse();
    check("to_pre", 32'(show_new_time), 32'h1);
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    check("to_flags", 32'(flags()), 32'b0000);
    check("to_buf", 32'(key_buffer), 32'h0);
    tick();

    // Digit coincident with third pulse wins
    press(4'd5, 2);
    pulse();
    pulse();
    one_second = 1'b1;
    key = 4'd6;
    tick();
    one_second = 1'b0;
    check("race_buf", 32'(key_buffer), 32'h0056);
    check("race_snt", 32'(show_new_time), 32'h1);
    tick();
    key = 4'd15;
    tick();
    key = 4'd11;
    tick();
    check("race_load", 32'(flags()), 32'b0001);
    key = 4'd15;
    tick();

    // Timeout while still holding the key in KEY_WAITED
    key = 4'd3;
    tick();
    tick();
    pulse();
    pulse();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    key = 4'd15;
    check("heldto_flags", 32'(flags()), 32'b0000);
    check("heldto_buf", 32'(key_buffer), 32'h0);
    tick();

    // Restore a known buffer for the alarm view
    press(4'd5, 2);
    press(4'd6, 2);
    key = 4'd11;
    tick();
    key = 4'd15;
    tick();

    // Alarm view
    key = 4'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("av_on", 32'(flags()), 32'b0100);
    end
    key = 4'd15;
    tick();
    check("av_off", 32'(flags()), 32'b0000);
    key = 4'd10;
    tick();
    key = 4'd9;
    tick();
    key = 4'd15;
    check("av_digit_flags", 32'(flags()), 32'b0000);
    check("av_digit_buf", 32'(key_buffer), 32'h0056);
    tick();
    check("av_idle_buf", 32'(key_buffer), 32'h0056);

    // Asynchronous reset mid-entry
    press(4'd1, 2);
    press(4'd2, 2);
    check("rst_pre_buf", 32'(key_buffer), 32'h0012);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_buf", 32'(key_buffer), 32'h0);
    check("rst_async_flags", 32'(flags()), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_post", {12'h0, flags(), key_buffer}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
